// File: rtl/cusio_host_sequencer.sv
// Host-side bus initiator for the custom I/O chip register port.
// Configures coin tables, captures DIP banks, then polls frame data on VBLK.
module cusio_host_sequencer #(
    parameter int GAP_CYC  = 1,
    parameter int POLL_DIV = 1
) (
    input  logic       CL,
    input  logic       RESET,
    input  logic       START,
    input  logic       SW_MODE,
    input  logic [3:0] CFG_CIN1,
    input  logic [3:0] CFG_CRE1,
    input  logic [3:0] CFG_CIN2,
    input  logic [3:0] CFG_CRE2,
    input  logic       VBLK,
    output logic       CS,
    output logic       WR,
    output logic [4:0] AD,
    output logic [7:0] WD,
    input  logic [7:0] RD,
    output logic [7:0] DSW0_Q,
    output logic [7:0] DSW1_Q,
    output logic [7:0] FRM0,
    output logic [7:0] FRM1,
    output logic [7:0] FRM2,
    output logic       FRAME_VLD,
    output logic       BUSY,
    output logic       CMD_ERR,
    output logic       OVERRUN
);

    // At least one idle cycle always separates two strobes
    localparam int GAP_EFF = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam logic [3:0] GAP_LAST = 4'(GAP_EFF - 1);
    localparam logic [3:0] DIV_LAST = 4'(POLL_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ACC,
        S_GAP
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic       pol;
    logic [3:0] gcnt;
    logic [3:0] pdiv;
    logic       vblk_d;
    logic       sw;
    logic [3:0] cin1, cre1, cin2, cre2;
    logic [7:0] h0, h1;

    logic       acc_wr;
    logic [4:0] acc_ad;
    logic [7:0] acc_wd;
    logic [7:0] exp_d;
    logic       chk;
    logic [3:0] nxt_idx;
    logic       done;
    logic       in_run;
    logic       start_ok;
    logic       rise;

    assign in_run   = (state == S_RUN) || pol;
    assign start_ok = START && ((state == S_IDLE) || in_run);
    assign rise     = VBLK & ~vblk_d;

    // Access descriptor for the step held in idx
    always_comb begin
        acc_wr = 1'b0;
        acc_ad = 5'h00;
        acc_wd = 8'h00;
        exp_d  = 8'h00;
        chk    = 1'b0;
        if (pol) begin
            acc_ad = {3'b000, idx[1:0]};
        end else begin
            case (idx)
                4'd0: begin
                    acc_wr = 1'b1;
                    acc_ad = 5'h10;
                    acc_wd = 8'hC1;
                end
                4'd1: begin
                    acc_ad = 5'h10;
                    chk    = 1'b1;
                    exp_d  = 8'hC1;
                end
                4'd2: begin
                    acc_wr = 1'b1;
                    acc_ad = 5'h02;
                    acc_wd = {4'h0, cin1};
                end
                4'd3: begin
                    acc_wr = 1'b1;
                    acc_ad = 5'h03;
                    acc_wd = {4'h0, cre1};
                end
                4'd4: begin
                    acc_wr = 1'b1;
                    acc_ad = 5'h04;
                    acc_wd = {4'h0, cin2};
                end
                4'd5: begin
                    acc_wr = 1'b1;
                    acc_ad = 5'h05;
                    acc_wd = {4'h0, cre2};
                end
                4'd6: begin
                    acc_wr = 1'b1;
                    acc_ad = 5'h08;
                end
                4'd7: begin
                    acc_wr = 1'b1;
                    acc_ad = 5'h10;
                    acc_wd = 8'hD2;
                end
                4'd8: begin
                    acc_ad = 5'h10;
                    chk    = 1'b1;
                    exp_d  = 8'hD2;
                end
                4'd9:  acc_ad = 5'h00;
                4'd10: acc_ad = 5'h01;
                4'd11: begin
                    acc_wr = 1'b1;
                    acc_ad = 5'h10;
                    acc_wd = 8'hA1;
                end
                4'd12: begin
                    acc_ad = 5'h10;
                    chk    = 1'b1;
                    exp_d  = 8'hA1;
                end
                4'd13: begin
                    acc_wr = 1'b1;
                    acc_ad = 5'h10;
                    acc_wd = 8'h71;
                end
                4'd14: begin
                    acc_ad = 5'h10;
                    chk    = 1'b1;
                    exp_d  = 8'h71;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt_idx = idx + 4'd1;
        if (!pol && idx == 4'd10 && !sw)
            nxt_idx = 4'd13;
        done = pol ? (idx == 4'd3) : (idx == 4'd15);
    end

    always_ff @(posedge CL or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            idx       <= 4'd0;
            pol       <= 1'b0;
            gcnt      <= 4'd0;
            pdiv      <= 4'd0;
            vblk_d    <= 1'b0;
            sw        <= 1'b0;
            cin1      <= 4'h0;
            cre1      <= 4'h0;
            cin2      <= 4'h0;
            cre2      <= 4'h0;
            h0        <= 8'h00;
            h1        <= 8'h00;
            CS        <= 1'b0;
            WR        <= 1'b0;
            AD        <= 5'h00;
            WD        <= 8'h00;
            DSW0_Q    <= 8'h00;
            DSW1_Q    <= 8'h00;
            FRM0      <= 8'h00;
            FRM1      <= 8'h00;
            FRM2      <= 8'h00;
            FRAME_VLD <= 1'b0;
            BUSY      <= 1'b0;
            CMD_ERR   <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            vblk_d    <= VBLK;
            FRAME_VLD <= 1'b0;
            if (start_ok) begin
                // Restart always passes through a gap so CS cannot double-strobe
                state <= S_GAP;
                gcnt  <= 4'd0;
                idx   <= 4'd0;
                pol   <= 1'b0;
                pdiv  <= 4'd0;
                BUSY  <= 1'b1;
                CS    <= 1'b0;
                WR    <= 1'b0;
                AD    <= 5'h00;
                WD    <= 8'h00;
                sw    <= SW_MODE;
                cin1  <= CFG_CIN1;
                cre1  <= CFG_CRE1;
                cin2  <= CFG_CIN2;
                cre2  <= CFG_CRE2;
            end else begin
                case (state)
                    S_ACC: begin
                        CS    <= 1'b0;
                        WR    <= 1'b0;
                        AD    <= 5'h00;
                        WD    <= 8'h00;
                        gcnt  <= 4'd0;
                        idx   <= nxt_idx;
                        state <= S_GAP;
                        if (pol) begin
                            case (idx[1:0])
                                2'd0: h0 <= RD;
                                2'd1: h1 <= RD;
                                default: begin
                                    FRM0      <= h0;
                                    FRM1      <= h1;
                                    FRM2      <= RD;
                                    FRAME_VLD <= 1'b1;
                                end
                            endcase
                        end else begin
                            if (chk && RD != exp_d)
                                CMD_ERR <= 1'b1;
                            if (idx == 4'd9)
                                DSW0_Q <= RD;
                            if (idx == 4'd10)
                                DSW1_Q <= RD;
                        end
                    end
                    S_GAP: begin
                        if (gcnt == GAP_LAST) begin
                            if (done) begin
                                state <= S_RUN;
                                pol   <= 1'b0;
                                BUSY  <= 1'b0;
                            end else begin
                                state <= S_ACC;
                                CS    <= 1'b1;
                                WR    <= acc_wr;
                                AD    <= acc_ad;
                                WD    <= acc_wd;
                            end
                        end else begin
                            gcnt <= gcnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
                if (in_run && rise) begin
                    if (pdiv == DIV_LAST) begin
                        pdiv <= 4'd0;
                        if (state == S_RUN) begin
                            state <= S_ACC;
                            pol   <= 1'b1;
                            idx   <= 4'd0;
                            CS    <= 1'b1;
                            WR    <= 1'b0;
                            AD    <= 5'h00;
                            WD    <= 8'h00;
                        end else begin
                            OVERRUN <= 1'b1;
                        end
                    end else begin
                        pdiv <= pdiv + 4'd1;
                    end
                end
            end
        end
    end

endmodule
